// File: rtl/nexys_starship_hull_pkg.sv
// nexys_starship_hull_pkg: shared state encodings and part indices
// for the hull-integrity controller.
package nexys_starship_hull_pkg;

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_PLAY = 3'b010;
    localparam logic [2:0] ST_OVER = 3'b100;

    localparam int LEFT   = 0;
    localparam int RIGHT  = 1;
    localparam int TOP    = 2;
    localparam int BOTTOM = 3;

endpackage

// File: rtl/nexys_starship_hull_if.sv
// nexys_starship_hull_if: game inputs from the repair SMs and
// buttons, plus the hull status outputs.
interface nexys_starship_hull_if #(
    parameter int NUM_PARTS = 4,
    parameter int DMG_W     = 8,
    parameter int SCORE_W   = 16
);
    logic                 play_flag;
    logic                 timer_tick;
    logic                 restart;
    logic [NUM_PARTS-1:0] broken;

    logic                 gameover_ctrl;
    logic                 damage_warn;
    logic [DMG_W-1:0]     damage;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   repairs;
    logic                 q_Idle;
    logic                 q_Play;
    logic                 q_Over;

    modport master (
        output play_flag, timer_tick, restart, broken,
        input  gameover_ctrl, damage_warn, damage,
        input  score, repairs, q_Idle, q_Play, q_Over
    );

    modport slave (
        input  play_flag, timer_tick, restart, broken,
        output gameover_ctrl, damage_warn, damage,
        output score, repairs, q_Idle, q_Play, q_Over
    );
endinterface

// File: rtl/nexys_starship_hull_popcount.sv
// nexys_starship_hull_popcount: combinational count of set bits
// in a W-bit vector.
module nexys_starship_hull_popcount #(
    parameter int W  = 4,
    parameter int CW = 3
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end
endmodule

// File: rtl/nexys_starship_hull.sv
// nexys_starship_hull: hull damage, score and repair tally with
// idle/play/over game control driving gameover_ctrl.
module nexys_starship_hull
    import nexys_starship_hull_pkg::*;
#(
    parameter int NUM_PARTS  = 4,
    parameter int DMG_W      = 8,
    parameter int MAX_DAMAGE = 100,
    parameter int SCORE_W    = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    nexys_starship_hull_if.slave bus
);
    localparam int CW = $clog2(NUM_PARTS + 1);
    localparam logic [DMG_W:0] MAX_SUM =
        (DMG_W+1)'(MAX_DAMAGE);
    localparam logic [DMG_W-1:0] MAX_DMG =
        DMG_W'(MAX_DAMAGE);
    localparam logic [DMG_W-1:0] WARN_LVL =
        DMG_W'((3 * MAX_DAMAGE) / 4);

    logic [2:0]           state;
    logic [DMG_W-1:0]     damage;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   repairs;
    logic [NUM_PARTS-1:0] broken_d;
    logic [NUM_PARTS-1:0] fixed;
    logic [CW-1:0]        n_broken;
    logic [CW-1:0]        n_fixed;
    logic [DMG_W:0]       dmg_sum;
    logic [SCORE_W:0]     rep_sum;
    logic [SCORE_W-1:0]   rep_next;
    logic [SCORE_W-1:0]   score_inc;

    // A part counts as repaired on its broken->ok transition.
    assign fixed = broken_d & ~bus.broken;

    nexys_starship_hull_popcount #(
        .W  (NUM_PARTS),
        .CW (CW)
    ) u_pop_broken (
        .bits  (bus.broken),
        .count (n_broken)
    );

    nexys_starship_hull_popcount #(
        .W  (NUM_PARTS),
        .CW (CW)
    ) u_pop_fixed (
        .bits  (fixed),
        .count (n_fixed)
    );

    assign dmg_sum = {1'b0, damage} + (DMG_W+1)'(n_broken);
    assign rep_sum = {1'b0, repairs} + (SCORE_W+1)'(n_fixed);
    assign rep_next = rep_sum[SCORE_W] ? '1
                                       : rep_sum[SCORE_W-1:0];
    assign score_inc = (&score) ? score
                                : score + SCORE_W'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            damage   <= '0;
            score    <= '0;
            repairs  <= '0;
            broken_d <= '0;
        end else begin
            broken_d <= bus.broken;
            case (state)
                ST_IDLE: begin
                    damage  <= '0;
                    score   <= '0;
                    repairs <= '0;
                    if (bus.play_flag) state <= ST_PLAY;
                end
                ST_PLAY: begin
                    repairs <= rep_next;
                    if (bus.timer_tick) begin
                        if (dmg_sum >= MAX_SUM) begin
                            damage <= MAX_DMG;
                            state  <= ST_OVER;
                        end else begin
                            damage <= dmg_sum[DMG_W-1:0];
                            score  <= score_inc;
                        end
                    end
                end
                ST_OVER: begin
                    if (bus.restart) begin
                        state   <= ST_IDLE;
                        damage  <= '0;
                        score   <= '0;
                        repairs <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    damage  <= '0;
                    score   <= '0;
                    repairs <= '0;
                end
            endcase
        end
    end

    assign bus.damage        = damage;
    assign bus.score         = score;
    assign bus.repairs       = repairs;
    assign bus.damage_warn   = (damage >= WARN_LVL);
    assign bus.gameover_ctrl = (state == ST_OVER);
    assign bus.q_Idle        = state[0];
    assign bus.q_Play        = state[1];
    assign bus.q_Over        = state[2];
endmodule

// File: tb/tb_nexys_starship_hull.sv
// tb_nexys_starship_hull: directed scenario tasks with
// hand-computed expectations for the hull controller.
module tb_nexys_starship_hull;
    import nexys_starship_hull_pkg::*;

    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    nexys_starship_hull_if #(
        .NUM_PARTS (4),
        .DMG_W     (8),
        .SCORE_W   (16)
    ) bus ();

    nexys_starship_hull #(
        .NUM_PARTS  (4),
        .DMG_W      (8),
        .MAX_DAMAGE (100),
        .SCORE_W    (16)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_tick(input logic [3:0] brk);
        bus.broken     = brk;
        bus.timer_tick = 1'b1;
        cycle();
        bus.timer_tick = 1'b0;
        cycle();
    endtask

    function automatic logic [2:0] q_vec();
        return {bus.q_Over, bus.q_Play, bus.q_Idle};
    endfunction

    task automatic test_reset();
        Reset          = 1'b1;
        bus.play_flag  = 1'b0;
        bus.timer_tick = 1'b0;
        bus.restart    = 1'b0;
        bus.broken     = '0;
        cycle();
        cycle();
        Reset = 1'b0;
        total++;
        if (q_vec() !== ST_IDLE) begin
            bad++;
            $display("FAIL rst_state: got %b want %b",
                     q_vec(), ST_IDLE);
        end
        total++;
        if ({bus.damage, bus.score, bus.repairs} !== '0) begin
            bad++;
            $display("FAIL rst_cnt: got %0d/%0d/%0d want 0",
                     bus.damage, bus.score, bus.repairs);
        end
        total++;
        if ({bus.gameover_ctrl, bus.damage_warn} !== 2'b00) begin
            bad++;
            $display("FAIL rst_flags: got %b%b want 00",
                     bus.gameover_ctrl, bus.damage_warn);
        end
    endtask

    task automatic test_play_score();
        bus.play_flag = 1'b1;
        cycle();
        bus.play_flag = 1'b0;
        repeat (10) do_tick(4'b0000);
        total++;
        if (q_vec() !== ST_PLAY) begin
            bad++;
            $display("FAIL play_state: got %b want %b",
                     q_vec(), ST_PLAY);
        end
        total++;
        if (bus.score !== 16'd10) begin
            bad++;
            $display("FAIL score_10: got %0d want 10",
                     bus.score);
        end
        total++;
        if (bus.damage !== 8'd0 || bus.gameover_ctrl !== 1'b0) begin
            bad++;
            $display("FAIL play_dmg: got %0d/%b want 0/0",
                     bus.damage, bus.gameover_ctrl);
        end
    endtask

    task automatic test_damage_repair();
        repeat (5) do_tick(4'b0011);
        total++;
        if (bus.damage !== 8'd10) begin
            bad++;
            $display("FAIL dmg_10: got %0d want 10", bus.damage);
        end
        bus.broken = 4'b0001;
        cycle();
        total++;
        if (bus.repairs !== 16'd1) begin
            bad++;
            $display("FAIL rep_1: got %0d want 1", bus.repairs);
        end
        total++;
        if (bus.damage !== 8'd10 || bus.score !== 16'd15) begin
            bad++;
            $display("FAIL notick: got %0d/%0d want 10/15",
                     bus.damage, bus.score);
        end
    endtask

    task automatic test_gameover();
        repeat (16) do_tick(4'b1111);
        total++;
        if (bus.damage !== 8'd74 || bus.damage_warn !== 1'b0) begin
            bad++;
            $display("FAIL warn_74: got %0d/%b want 74/0",
                     bus.damage, bus.damage_warn);
        end
        do_tick(4'b0001);
        total++;
        if (bus.damage !== 8'd75 || bus.damage_warn !== 1'b1) begin
            bad++;
            $display("FAIL warn_75: got %0d/%b want 75/1",
                     bus.damage, bus.damage_warn);
        end
        total++;
        if (bus.repairs !== 16'd4) begin
            bad++;
            $display("FAIL rep_4: got %0d want 4", bus.repairs);
        end
        repeat (5) do_tick(4'b1111);
        repeat (3) do_tick(4'b0001);
        total++;
        if (bus.damage !== 8'd98 || bus.score !== 16'd40) begin
            bad++;
            $display("FAIL pre_kill: got %0d/%0d want 98/40",
                     bus.damage, bus.score);
        end
        bus.broken     = 4'b1111;
        bus.timer_tick = 1'b1;
        cycle();
        bus.timer_tick = 1'b0;
        total++;
        if (bus.damage !== 8'd100 || bus.score !== 16'd40) begin
            bad++;
            $display("FAIL kill_cnt: got %0d/%0d want 100/40",
                     bus.damage, bus.score);
        end
        total++;
        if (q_vec() !== ST_OVER || bus.gameover_ctrl !== 1'b1) begin
            bad++;
            $display("FAIL kill_state: got %b/%b want %b/1",
                     q_vec(), bus.gameover_ctrl, ST_OVER);
        end
        total++;
        if (bus.repairs !== 16'd7) begin
            bad++;
            $display("FAIL rep_7: got %0d want 7", bus.repairs);
        end
    endtask

    task automatic test_over_frozen();
        repeat (3) do_tick(4'b1111);
        bus.broken = 4'b0000;
        cycle();
        total++;
        if (bus.damage !== 8'd100 || bus.score !== 16'd40 ||
            bus.repairs !== 16'd7) begin
            bad++;
            $display("FAIL frozen: got %0d/%0d/%0d want 100/40/7",
                     bus.damage, bus.score, bus.repairs);
        end
        total++;
        if (bus.gameover_ctrl !== 1'b1) begin
            bad++;
            $display("FAIL over_hold: got %b want 1",
                     bus.gameover_ctrl);
        end
        bus.broken     = 4'b1111;
        bus.restart    = 1'b1;
        bus.timer_tick = 1'b1;
        cycle();
        bus.restart    = 1'b0;
        bus.timer_tick = 1'b0;
        total++;
        if (q_vec() !== ST_IDLE || bus.gameover_ctrl !== 1'b0) begin
            bad++;
            $display("FAIL restart: got %b/%b want %b/0",
                     q_vec(), bus.gameover_ctrl, ST_IDLE);
        end
        total++;
        if ({bus.damage, bus.score, bus.repairs} !== '0) begin
            bad++;
            $display("FAIL restart_cnt: got %0d/%0d/%0d want 0",
                     bus.damage, bus.score, bus.repairs);
        end
    endtask

    task automatic test_reset_midgame();
        bus.broken    = 4'b0000;
        bus.play_flag = 1'b1;
        cycle();
        repeat (7) do_tick(4'b1111);
        total++;
        if (bus.damage !== 8'd28 || bus.score !== 16'd7) begin
            bad++;
            $display("FAIL mid_pre: got %0d/%0d want 28/7",
                     bus.damage, bus.score);
        end
        Reset          = 1'b1;
        bus.timer_tick = 1'b1;
        bus.broken     = 4'b0000;
        cycle();
        Reset          = 1'b0;
        bus.timer_tick = 1'b0;
        total++;
        if (q_vec() !== ST_IDLE) begin
            bad++;
            $display("FAIL mid_rst: got %b want %b",
                     q_vec(), ST_IDLE);
        end
        total++;
        if ({bus.damage, bus.score, bus.repairs} !== '0) begin
            bad++;
            $display("FAIL mid_cnt: got %0d/%0d/%0d want 0",
                     bus.damage, bus.score, bus.repairs);
        end
    endtask

    task automatic test_exact_max();
        cycle();
        bus.play_flag = 1'b0;
        repeat (24) do_tick(4'b1111);
        total++;
        if (bus.damage !== 8'd96 || q_vec() !== ST_PLAY) begin
            bad++;
            $display("FAIL exact_pre: got %0d/%b want 96/%b",
                     bus.damage, q_vec(), ST_PLAY);
        end
        do_tick(4'b1111);
        total++;
        if (bus.damage !== 8'd100 || bus.score !== 16'd24 ||
            q_vec() !== ST_OVER) begin
            bad++;
            $display("FAIL exact_max: got %0d/%0d/%b want 100/24/%b",
                     bus.damage, bus.score, q_vec(), ST_OVER);
        end
        bus.restart = 1'b1;
        cycle();
        bus.restart = 1'b0;
    endtask

    task automatic test_idle_broken();
        bus.broken = 4'b1111;
        cycle();
        cycle();
        bus.broken    = 4'b0000;
        bus.play_flag = 1'b1;
        cycle();
        bus.play_flag = 1'b0;
        cycle();
        cycle();
        total++;
        if (q_vec() !== ST_PLAY || bus.repairs !== 16'd0) begin
            bad++;
            $display("FAIL idle_brk: got %b/%0d want %b/0",
                     q_vec(), bus.repairs, ST_PLAY);
        end
    endtask

    task automatic test_score_sat();
        bus.broken     = 4'b0000;
        bus.timer_tick = 1'b1;
        repeat (65535) @(posedge Clk);
        #1;
        total++;
        if (bus.score !== 16'hFFFF) begin
            bad++;
            $display("FAIL score_max: got %h want ffff", bus.score);
        end
        cycle();
        cycle();
        bus.timer_tick = 1'b0;
        total++;
        if (bus.score !== 16'hFFFF || bus.damage !== 8'd0) begin
            bad++;
            $display("FAIL score_sat: got %h/%0d want ffff/0",
                     bus.score, bus.damage);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_play_score();
        test_damage_repair();
        test_gameover();
        test_over_frozen();
        test_reset_midgame();
        test_exact_max();
        test_idle_broken();
        test_score_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
